// File: rtl/campfire_ctrl.sv
// campfire_ctrl: campfire checkpoint controller.
// A single overlap comparator is time-shared across N campfires by a
// round-robin scanner that runs while the player is alive and idle. A hit
// on a campfire other than the current checkpoint latches it as the new
// respawn point. A death runs fade-out, a one-cycle teleport strobe, and
// fade-in, then waits for the player to come back to life.
// Optional build macro: CAMPFIRE_HEAL_EN adds heal_pulse, a periodic strobe
// issued while the player stands on the active campfire.
module campfire_ctrl #(
  parameter int          N           = 4,
  parameter int          IDX_W       = 2,
  parameter logic [19:0] DEFAULT_POS = 20'h0A_0C8,
  parameter int          HEAL_PERIOD = 30
) (
  input  logic              sim_clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic [19:0]       playerPos,
  input  logic [20*N-1:0]   camp_xy,
  input  logic [19:0]       camp_size,
  input  logic              player_dead,
  output logic              respawn_pulse,
  output logic [19:0]       respawn_pos,
  output logic              checkpoint_valid,
  output logic [IDX_W-1:0]  active_idx,
  output logic              activate_pulse,
  output logic [3:0]        fade_level,
  output logic              busy
`ifdef CAMPFIRE_HEAL_EN
  ,
  output logic              heal_pulse
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FADE_OUT,
    S_TELEPORT,
    S_FADE_IN,
    S_WAIT_ALIVE
  } state_t;

  // The index space is padded to a power of two so any scan_idx value
  // selects a defined entry; unused slots read as zero and are never scanned.
  localparam int SLOTS = 1 << IDX_W;

  state_t           state_q, state_d;
  logic [3:0]       fade_q, fade_d;
  logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
  logic [IDX_W-1:0] active_idx_q;
  logic [19:0]      respawn_pos_q;
  logic             valid_q;
  logic             activate_q, activate_d;

  logic [19:0]      camp_arr [SLOTS];
  logic [19:0]      cur_camp;
  logic [9:0]       px, py, cx, cy;
  logic [10:0]      x_hi, y_hi;
  logic             scan_hit;

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_camp
      if (gi < N) begin : g_used
        assign camp_arr[gi] = camp_xy[20*gi +: 20];
      end else begin : g_pad
        assign camp_arr[gi] = 20'd0;
      end
    end
  endgenerate

  // Shared comparator: inclusive box test on the campfire under scan.
  // Upper bounds are 11 bits wide so a box running past 1023 still covers
  // the right/bottom edge instead of wrapping.
  always_comb begin
    cur_camp = camp_arr[scan_idx_q];
    px       = playerPos[19:10];
    py       = playerPos[9:0];
    cx       = cur_camp[19:10];
    cy       = cur_camp[9:0];
    x_hi     = {1'b0, cx} + {1'b0, camp_size[19:10]};
    y_hi     = {1'b0, cy} + {1'b0, camp_size[9:0]};
    scan_hit = (px >= cx) && ({1'b0, px} <= x_hi) &&
               (py >= cy) && ({1'b0, py} <= y_hi);
  end

  // Scanner advance and activation decision; a death in the same cycle
  // wins over a hit so the checkpoint never moves once dying has begun.
  always_comb begin
    scan_idx_d = scan_idx_q;
    activate_d = 1'b0;
    if (state_q == S_IDLE) begin
      if (scan_idx_q == IDX_W'(N - 1)) begin
        scan_idx_d = '0;
      end else begin
        scan_idx_d = scan_idx_q + 1'b1;
      end
      activate_d = !player_dead && scan_hit &&
                   (!valid_q || (scan_idx_q != active_idx_q));
    end
  end

  // Respawn sequencer next state, fade level and status outputs. A tick
  // arriving on a transition cycle is ignored because only the state being
  // left looks at it.
  always_comb begin
    state_d       = state_q;
    fade_d        = fade_q;
    respawn_pulse = 1'b0;
    busy          = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (player_dead) begin
          state_d = S_FADE_OUT;
        end
      end
      S_FADE_OUT: begin
        if (frame_tick) begin
          fade_d = (fade_q == 4'd15) ? 4'd15 : fade_q + 4'd1;
          if (fade_d == 4'd15) begin
            state_d = S_TELEPORT;
          end
        end
      end
      S_TELEPORT: begin
        respawn_pulse = 1'b1;
        state_d       = S_FADE_IN;
      end
      S_FADE_IN: begin
        if (frame_tick) begin
          fade_d = (fade_q == 4'd0) ? 4'd0 : fade_q - 4'd1;
          if (fade_d == 4'd0) begin
            state_d = S_WAIT_ALIVE;
          end
        end
      end
      S_WAIT_ALIVE: begin
        if (!player_dead) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, scanner and checkpoint registers. The checkpoint only moves
  // from IDLE, which keeps respawn_pos and active_idx frozen while busy.
  always_ff @(posedge sim_clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      fade_q        <= 4'd0;
      scan_idx_q    <= '0;
      active_idx_q  <= '0;
      respawn_pos_q <= DEFAULT_POS;
      valid_q       <= 1'b0;
      activate_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fade_q     <= fade_d;
      scan_idx_q <= scan_idx_d;
      activate_q <= activate_d;
      if (activate_d) begin
        active_idx_q  <= scan_idx_q;
        respawn_pos_q <= cur_camp;
        valid_q       <= 1'b1;
      end
    end
  end

  assign respawn_pos      = respawn_pos_q;
  assign checkpoint_valid = valid_q;
  assign active_idx       = active_idx_q;
  assign activate_pulse   = activate_q;
  assign fade_level       = fade_q;

`ifdef CAMPFIRE_HEAL_EN
  localparam int HCW = $clog2(HEAL_PERIOD + 1);

  logic           on_active_q, on_active_d;
  logic [HCW-1:0] heal_cnt_q, heal_cnt_d;
  logic           heal_pulse_q, heal_pulse_d;

  // Standing-on-checkpoint flag: refreshed whenever the active campfire is
  // rescanned, set by a fresh activation, dropped outside IDLE. The heal
  // counter runs on frame ticks only while that flag holds.
  always_comb begin
    on_active_d  = on_active_q;
    heal_cnt_d   = heal_cnt_q;
    heal_pulse_d = 1'b0;
    if (state_q != S_IDLE) begin
      on_active_d = 1'b0;
    end else if (activate_d) begin
      on_active_d = 1'b1;
    end else if (valid_q && (scan_idx_q == active_idx_q)) begin
      on_active_d = scan_hit;
    end
    if ((state_q != S_IDLE) || !on_active_q) begin
      heal_cnt_d = '0;
    end else if (frame_tick) begin
      if (heal_cnt_q == HCW'(HEAL_PERIOD - 1)) begin
        heal_cnt_d   = '0;
        heal_pulse_d = 1'b1;
      end else begin
        heal_cnt_d = heal_cnt_q + 1'b1;
      end
    end
  end

  // Heal registers.
  always_ff @(posedge sim_clk) begin
    if (reset) begin
      on_active_q  <= 1'b0;
      heal_cnt_q   <= '0;
      heal_pulse_q <= 1'b0;
    end else begin
      on_active_q  <= on_active_d;
      heal_cnt_q   <= heal_cnt_d;
      heal_pulse_q <= heal_pulse_d;
    end
  end

  assign heal_pulse = heal_pulse_q;
`endif

endmodule

// File: doc/campfire_ctrl.md
Name: campfire_ctrl

Overview:
- Controller for the level's campfire checkpoints. Shares one overlap comparator across N campfires by round-robin time-multiplexing. Latches the most recently touched campfire as the active checkpoint.
- Sequences the death/respawn flow: fade out, teleport pulse, fade in.
- Sits between the player physics block (playerPos, player_dead) and the renderer/physics consumers (fade_level, respawn_pulse, respawn_pos).

Parameters:
N, 4, number of campfires (2..4).
IDX_W, 2, width of the campfire index.
DEFAULT_POS, 20'h0A_0C8, respawn {x,y} used when no checkpoint has been activated.
HEAL_PERIOD, 30, frame_ticks per heal pulse (optional feature only).

Ports:
sim_clk  in  1  system clock; all logic on its rising edge.
reset  in  1  synchronous, active-high reset.
frame_tick  in  1  one-cycle pulse once per video frame.
playerPos  in  20  player {x[19:10], y[9:0]}.
camp_xy  in  20*N  campfire i origin {x,y} at bits [20i+19:20i].
camp_size  in  20  shared {width[19:10], height[9:0]}.
player_dead  in  1  level; high while the player is dead.
respawn_pulse  out  1  one-cycle teleport strobe.
respawn_pos  out  20  {x,y} respawn target.
checkpoint_valid  out  1  high once any campfire has been activated.
active_idx  out  IDX_W  index of the active campfire.
activate_pulse  out  1  one-cycle strobe when a new checkpoint latches.
fade_level  out  4  0 = clear, 15 = black.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: respawn_pos=DEFAULT_POS; all other outputs 0; scan_idx=0; state=IDLE.
  - Reset asserted mid-sequence aborts on the next edge.
- Scanner runs only in IDLE.
  - Each cycle, test campfire scan_idx, then advance scan_idx, wrapping N-1 -> 0.
  - Full sweep takes N cycles.
- Overlap test is inclusive: cx <= px <= cx+w and cy <= py <= cy+h.
  - Sums are computed at 11 bits; no wrap, so a sum >1023 still covers px=1023.
- Activation: registered one cycle after the test.
  - Fires on a hit when checkpoint_valid=0 or scan_idx != active_idx.
  - Sets active_idx=scan_idx, respawn_pos={cx,cy}, checkpoint_valid=1, activate_pulse=1 for one cycle.
  - Re-touching the active campfire generates no pulse.
- FSM states: IDLE, FADE_OUT, TELEPORT, FADE_IN, WAIT_ALIVE.
  - IDLE: player_dead=1 -> FADE_OUT next cycle. The scan result of that cycle is discarded (death beats activation).
  - FADE_OUT: fade_level +1 per frame_tick. On the tick that makes it 15 -> TELEPORT.
  - TELEPORT: one cycle; respawn_pulse=1, respawn_pos held. -> FADE_IN.
  - FADE_IN: fade_level -1 per frame_tick. On reaching 0 -> WAIT_ALIVE.
  - WAIT_ALIVE: player_dead=0 -> IDLE. Otherwise hold; no retrigger until player_dead deasserts.
- fade_level saturates at 0 and 15 and changes only on frame_tick.
- Minimum death-to-pulse latency: 1 cycle to enter FADE_OUT, 15 frame_ticks, then 1 cycle.
- respawn_pos and active_idx are frozen while busy=1.
- frame_tick in the same cycle as a state transition is consumed by the new state only from the following cycle.

Optional Feature:
- Macro CAMPFIRE_HEAL_EN.
- When defined:
  - Adds output heal_pulse (1 bit) and a frame counter.
  - While in IDLE with the player overlapping the active campfire (registered scan hit on active_idx, held until that index is rescanned as a miss), count frame_ticks.
  - Every HEAL_PERIOD ticks, assert heal_pulse for one cycle.
  - Leaving overlap or leaving IDLE clears the counter.
- When undefined: no heal_pulse port and no counter; all other behaviour is identical.

Test Plan:
- Reset then idle, no overlap -> respawn_pos=20'h0A_0C8, checkpoint_valid=0, fade_level=0, busy=0 indefinitely.
- Campfire 2 at {x=200,y=300}, size {16,16}, playerPos {208,316} -> within N+1 cycles activate_pulse once, active_idx=2, respawn_pos={200,300}; holding position gives no further pulse.
- Boundary: campfire at {1020,100}, w=16, player x=1023 -> hit. Player x=1019 -> no hit.
- With checkpoint at campfire 2, assert player_dead -> busy next cycle; fade_level 1..15 over 15 ticks; single respawn_pulse with respawn_pos={200,300}; fade 15..0; stays WAIT_ALIVE until player_dead=0, then IDLE.
- player_dead rises in the same cycle campfire 1 is hit -> no activate_pulse, active_idx unchanged, FADE_OUT entered.
- Reset pulse during FADE_OUT at fade_level=7 -> next cycle fade_level=0, busy=0, checkpoint_valid=0, respawn_pos=DEFAULT_POS.
